// File: rtl/seven_segment_pkg.sv
// Shared segment type and digit codes for the two-digit seven-segment driver.
// Bit order is {g,f,e,d,c,b,a}; a 1 lights the segment.
package seven_segment_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'h3F;
   localparam seg_t SEG_1     = 7'h06;
   localparam seg_t SEG_2     = 7'h5B;
   localparam seg_t SEG_3     = 7'h4F;
   localparam seg_t SEG_4     = 7'h66;
   localparam seg_t SEG_5     = 7'h6D;
   localparam seg_t SEG_6     = 7'h7D;
   localparam seg_t SEG_7     = 7'h07;
   localparam seg_t SEG_8     = 7'h7F;
   localparam seg_t SEG_9     = 7'h6F;
   localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational BCD-to-segment decoder; codes 10-15 map to a dark digit.
module seven_segment_decoder
   import seven_segment_pkg::*;
(
   input  logic [3:0] bcd,
   output seg_t       seg
);

   always_comb begin
      seg = SEG_BLANK;
      unique case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_segment.sv
// Registered 0-31 binary to two-digit seven-segment driver (one cycle latency).
// Optional SEVEN_SEGMENT_LEADING_BLANK_EN darkens the tens digit for values 0-9.
module seven_segment
   import seven_segment_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] number,
   output logic [6:0] tens_digit,
   output logic [6:0] ones_digit
);

   logic [1:0] tens;
   logic [3:0] ones;
   seg_t       tens_seg;
   seg_t       ones_seg;
   seg_t       tens_shown;

   // Compare/subtract ladder; the 5-bit difference always fits in 4 bits.
   always_comb begin
      tens = 2'd0;
      ones = number[3:0];
      if (number >= 5'd30) begin
         tens = 2'd3;
         ones = 4'(number - 5'd30);
      end else if (number >= 5'd20) begin
         tens = 2'd2;
         ones = 4'(number - 5'd20);
      end else if (number >= 5'd10) begin
         tens = 2'd1;
         ones = 4'(number - 5'd10);
      end
   end

   seven_segment_decoder u_tens_dec (
      .bcd (4'({2'b00, tens})),
      .seg (tens_seg)
   );

   seven_segment_decoder u_ones_dec (
      .bcd (ones),
      .seg (ones_seg)
   );

`ifdef SEVEN_SEGMENT_LEADING_BLANK_EN
   assign tens_shown = (tens == 2'd0) ? SEG_BLANK : tens_seg;
`else
   assign tens_shown = tens_seg;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tens_digit <= SEG_BLANK;
         ones_digit <= SEG_BLANK;
      end else begin
         tens_digit <= tens_shown;
         ones_digit <= ones_seg;
      end
   end

endmodule

// File: tb/tb_seven_segment.sv
// Scoreboard bench for seven_segment: stimulus pushes expected pairs, a monitor
// pops and compares one cycle later; asynchronous reset is checked directly.
module tb_seven_segment;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] number = 5'd0;
   logic [6:0] tens_digit;
   logic [6:0] ones_digit;

   int n_tests = 0;
   int n_fail  = 0;

   logic [13:0] sb_q[$];
   string       name_q[$];

   seven_segment dut (
      .clk        (clk),
      .reset      (reset),
      .number     (number),
      .tens_digit (tens_digit),
      .ones_digit (ones_digit)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] tbl [10];
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return tbl[d];
   endfunction

   function automatic logic [13:0] model(input logic [4:0] v);
      int t;
      int o;
      logic [6:0] ts;
      t = int'(v) / 10;
      o = int'(v) % 10;
      ts = seg_of(t);
`ifdef SEVEN_SEGMENT_LEADING_BLANK_EN
      if (t == 0) ts = 7'h00;
`endif
      return {ts, seg_of(o)};
   endfunction

   task automatic check_now(input string nm, input logic [13:0] exp);
      n_tests++;
      if ({tens_digit, ones_digit} !== exp) begin
         n_fail++;
         $display("FAIL %s: got tens=%h ones=%h, expected tens=%h ones=%h",
                  nm, tens_digit, ones_digit, exp[13:7], exp[6:0]);
      end
   endtask

   // Applies inputs between edges and queues the response due after the next edge.
   task automatic drive(input string nm, input logic [4:0] v, input logic r);
      @(negedge clk);
      reset  = r;
      number = v;
      sb_q.push_back(r ? 14'h0 : model(v));
      name_q.push_back(nm);
   endtask

   // Monitor: the DUT presents a new output pair after every edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) check_now(name_q.pop_front(), sb_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion, expected finish before 100000");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] bnd [8];
      bnd = '{5'd9, 5'd10, 5'd19, 5'd20, 5'd29, 5'd30, 5'd31, 5'd0};

      #2;
      number = 5'd17;
      reset  = 1'b1;
      #1;
      check_now("reset_async", 14'h0);
      for (int i = 0; i < 3; i++) drive("reset_hold", 5'd17, 1'b1);

      drive("zero", 5'd0, 1'b0);
      foreach (bnd[i]) drive($sformatf("boundary_%0d", bnd[i]), bnd[i], 1'b0);

      for (int v = 0; v < 32; v++) begin
         drive($sformatf("sweep_%0d", v), 5'(v), 1'b0);
         if (v == 25) begin
            @(posedge clk);
            #2;
            check_now("pre_reset_25", {7'h5B, 7'h6D});
            reset = 1'b1;
            #1;
            check_now("midstream_reset", 14'h0);
            reset = 1'b0;
            #1;
            check_now("reset_released_no_edge", 14'h0);
         end
      end

      @(posedge clk);
      #3;
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
